// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and hands one instruction per cycle to decode with stall/branch/halt.
module fetch_unit #(
  parameter int                ADDR_W      = 16,
  parameter int                INST_W      = 26,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out,
  output logic              halted,
  output logic [31:0]       fetch_count,
  output logic [1:0]        dbg_state
);

  // Handshake: decode consumes inst_out in every cycle where valid_out=1 and
  // stall=0; a stalled instruction is held stable until it is consumed.
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [ADDR_W-1:0]   r_req_pc, w_req_pc_nxt;
  logic                r_req_valid, w_req_valid_nxt;
  logic [31:0]         r_fetch_count;
  logic                w_valid;
  logic                w_consume;
  logic                w_halt_hit;

  assign w_valid    = r_req_valid && (r_state != S_HALT);
  assign w_consume  = w_valid && !stall;
  assign w_halt_hit = w_consume && (imem_rdata[INST_W-1 -: 6] == HALT_OPCODE);

  assign valid_out   = w_valid;
  assign inst_out    = w_valid ? imem_rdata : '0;
  assign pc_out      = r_req_pc;
  assign halted      = (r_state == S_HALT);
  assign fetch_count = r_fetch_count;
  assign dbg_state   = r_state;

  always_comb begin
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_req_pc_nxt    = r_req_pc;
    w_req_valid_nxt = r_req_valid;
    imem_en         = 1'b0;
    imem_addr       = r_fetch_pc;
    case (r_state)
      S_BOOT: begin
        imem_en         = 1'b1;
        w_req_pc_nxt    = r_fetch_pc;
        w_req_valid_nxt = 1'b1;
        w_fetch_pc_nxt  = r_fetch_pc + ADDR_W'(1);
        w_state_nxt     = S_RUN;
      end
      S_RUN: begin
        if (w_halt_hit) begin
          w_state_nxt     = S_HALT;
          w_req_valid_nxt = 1'b0;
        end else if (branch_taken) begin
          // Redirect even when stalled; the stalled wrong-path slot is dropped.
          imem_en         = 1'b1;
          imem_addr       = branch_target;
          w_req_pc_nxt    = branch_target;
          w_req_valid_nxt = 1'b1;
          w_fetch_pc_nxt  = branch_target + ADDR_W'(1);
        end else if (!stall) begin
          imem_en         = 1'b1;
          w_req_pc_nxt    = r_fetch_pc;
          w_req_valid_nxt = 1'b1;
          w_fetch_pc_nxt  = r_fetch_pc + ADDR_W'(1);
        end
      end
      default: begin
      end
    endcase
    if (rst) imem_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= '0;
      r_req_valid   <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_req_valid <= w_req_valid_nxt;
      if (w_consume) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, branches, halt,
// reset recovery and PC wrap on a narrow-address instance.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (ADDR_W=16)
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [25:0] imem_rdata = '0;
  logic [25:0] inst_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic        halted;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  // Wrap instance (ADDR_W=4, RESET_PC=14)
  logic        rst_w = 1'b1;
  logic        imem_en_w;
  logic [3:0]  imem_addr_w;
  logic [25:0] imem_rdata_w = '0;
  logic [25:0] inst_out_w;
  logic [3:0]  pc_out_w;
  logic        valid_out_w;
  logic        halted_w;
  logic [31:0] fetch_count_w;
  logic [1:0]  dbg_state_w;

  logic        halt_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_out(inst_out), .pc_out(pc_out),
    .valid_out(valid_out), .halted(halted), .fetch_count(fetch_count),
    .dbg_state(dbg_state)
  );

  fetch_unit #(.ADDR_W(4), .RESET_PC(4'd14)) u_dut_w (
    .clk(clk), .rst(rst_w), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(4'd0), .imem_en(imem_en_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .inst_out(inst_out_w), .pc_out(pc_out_w),
    .valid_out(valid_out_w), .halted(halted_w), .fetch_count(fetch_count_w),
    .dbg_state(dbg_state_w)
  );

  // Memory contents: word i holds i, except a halt word at address 6 when enabled.
  function automatic logic [25:0] mem_word(input logic [15:0] a);
    if (halt_en && a == 16'd6) return {6'b111111, 20'h0};
    return {10'b0, a};
  endfunction

  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= mem_word(imem_addr);
    if (imem_en_w) imem_rdata_w <= {22'b0, imem_addr_w};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its S_BOOT cycle with rst released.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", {31'b0, valid_out}, 32'd0);
    check_eq("rst_pc", {16'b0, pc_out}, 32'd0);
    check_eq("rst_inst", {6'b0, inst_out}, 32'd0);
    check_eq("rst_count", fetch_count, 32'd0);
    check_eq("rst_imem_en", {31'b0, imem_en}, 32'd0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset and sequential fetch
    do_reset();
    check_eq("boot_valid", {31'b0, valid_out}, 32'd0);
    check_eq("boot_en", {31'b0, imem_en}, 32'd1);
    check_eq("boot_addr", {16'b0, imem_addr}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq("seq_pc", {16'b0, pc_out}, 32'(k - 1));
      check_eq("seq_inst", {6'b0, inst_out}, 32'(k - 1));
      check_eq("seq_valid", {31'b0, valid_out}, 32'd1);
    end
    tick();
    check_eq("seq_count", fetch_count, 32'd5);

    // Stall hold at pc 3
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    check_eq("pre_stall_pc", {16'b0, pc_out}, 32'd3);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("stall_en", {31'b0, imem_en}, 32'd0);
      check_eq("stall_pc", {16'b0, pc_out}, 32'd3);
      check_eq("stall_inst", {6'b0, inst_out}, 32'd3);
      check_eq("stall_count", fetch_count, 32'd3);
      tick();
    end
    stall = 1'b0;
    #1;
    check_eq("release_pc", {16'b0, pc_out}, 32'd3);
    tick();
    check_eq("post_stall_pc", {16'b0, pc_out}, 32'd4);
    check_eq("post_stall_inst", {6'b0, inst_out}, 32'd4);
    check_eq("post_stall_count", fetch_count, 32'd4);

    // Unstalled branch at pc 7
    do_reset();
    for (int k = 0; k < 8; k++) tick();
    check_eq("pre_br_pc", {16'b0, pc_out}, 32'd7);
    branch_taken = 1'b1; branch_target = 16'h0100;
    #1;
    check_eq("br_en", {31'b0, imem_en}, 32'd1);
    check_eq("br_addr", {16'b0, imem_addr}, 32'h0100);
    tick();
    branch_taken = 1'b0;
    check_eq("br_tgt_pc", {16'b0, pc_out}, 32'h0100);
    check_eq("br_tgt_inst", {6'b0, inst_out}, 32'h0100);
    check_eq("br_count", fetch_count, 32'd8);
    tick();
    check_eq("br_next_pc", {16'b0, pc_out}, 32'h0101);
    check_eq("br_next_count", fetch_count, 32'd9);

    // Stalled branch from pc 0x101
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0200;
    #1;
    check_eq("sbr_en", {31'b0, imem_en}, 32'd1);
    check_eq("sbr_addr", {16'b0, imem_addr}, 32'h0200);
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    check_eq("sbr_tgt_pc", {16'b0, pc_out}, 32'h0200);
    check_eq("sbr_tgt_inst", {6'b0, inst_out}, 32'h0200);
    check_eq("sbr_count", fetch_count, 32'd9);
    tick();
    check_eq("sbr_next_pc", {16'b0, pc_out}, 32'h0201);
    check_eq("sbr_next_count", fetch_count, 32'd10);

    // Halt at pc 6, with a competing branch
    halt_en = 1'b1;
    do_reset();
    for (int k = 0; k < 7; k++) tick();
    check_eq("halt_pc", {16'b0, pc_out}, 32'd6);
    check_eq("halt_inst", {6'b0, inst_out}, 32'h3F0_0000);
    branch_taken = 1'b1; branch_target = 16'h0300;
    #1;
    check_eq("halt_en_low", {31'b0, imem_en}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("halted", {31'b0, halted}, 32'd1);
      check_eq("halted_valid", {31'b0, valid_out}, 32'd0);
      check_eq("halted_inst", {6'b0, inst_out}, 32'd0);
      check_eq("halted_en", {31'b0, imem_en}, 32'd0);
      check_eq("halted_count", fetch_count, 32'd7);
    end
    branch_taken = 1'b0;

    // One-cycle reset out of halt
    rst = 1'b1;
    #1;
    check_eq("rerst_en", {31'b0, imem_en}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rerst_halted", {31'b0, halted}, 32'd0);
    check_eq("rerst_valid", {31'b0, valid_out}, 32'd0);
    check_eq("rerst_count", fetch_count, 32'd0);
    check_eq("rerst_boot_en", {31'b0, imem_en}, 32'd1);
    check_eq("rerst_boot_addr", {16'b0, imem_addr}, 32'd0);
    tick();
    check_eq("rerst_pc", {16'b0, pc_out}, 32'd0);
    check_eq("rerst_fetch_valid", {31'b0, valid_out}, 32'd1);
    halt_en = 1'b0;

    // PC wrap on the 4-bit instance
    rst_w = 1'b1;
    tick();
    tick();
    rst_w = 1'b0;
    #1;
    check_eq("wrap_boot_valid", {31'b0, valid_out_w}, 32'd0);
    begin
      logic [3:0] exp_pc [4];
      exp_pc = '{4'd14, 4'd15, 4'd0, 4'd1};
      for (int k = 0; k < 4; k++) begin
        tick();
        check_eq("wrap_pc", {28'b0, pc_out_w}, {28'b0, exp_pc[k]});
        check_eq("wrap_inst", {6'b0, inst_out_w}, {28'b0, exp_pc[k]});
        check_eq("wrap_valid", {31'b0, valid_out_w}, 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
